potential_update_array: RTL and testbench

POTENTIAL_UPDATE_ARRAY -- requirements
Module: potential_update_array

---
 rtl/potential_update_array.sv | 225 ++++++++++++++++++++++
 tb/tb_potential_update_array.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/potential_update_array.sv
// Float membrane-potential accumulator with a threshold sweep per timestep.
// Optional debug read tap enabled by defining POTENTIAL_DEBUG_TAP_EN.
module potential_update_array #(
   parameter int          NUM_NEURONS = 4,
   parameter logic [31:0] V_THRESHOLD = 32'h42200000,
   parameter int          RESET_MODE  = 0,
   localparam int         ID_W        = $clog2(NUM_NEURONS)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   clear,
   input  logic                   step,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ID_W-1:0]        in_neuron_id,
   input  logic [31:0]            in_weight,
`ifdef POTENTIAL_DEBUG_TAP_EN
   input  logic [ID_W-1:0]        dbg_sel,
   output logic [31:0]            dbg_potential,
   output logic [9:0]             dbg_bits,
`endif
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic                   step_done,
   output logic                   busy,
   output logic                   err_id,
   output logic                   err_fp
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EVAL,
      S_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [ID_W-1:0]               idx_q, idx_d;
   logic [NUM_NEURONS-1:0][31:0]  pot_q, pot_d;
   logic [NUM_NEURONS-1:0]        spike_q, spike_d;
   logic                          err_id_q, err_id_d;
   logic                          err_fp_q, err_fp_d;

   logic                          id_ok;
   logic [31:0]                   acc_cur;
   logic [31:0]                   eval_cur;
   logic [32:0]                   acc_res;
   logic [32:0]                   sub_res;

   // Round-to-nearest-even add; bit 32 flags inf/NaN input or overflow.
   function automatic logic [32:0] fp_add(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [31:0] x, y;
      logic        sx, sy, sr, sticky, rnd, is_norm, exc;
      logic [9:0]  ex, ey, er, d;
      logic [26:0] mx, my, m;
      logic [27:0] s;
      logic [24:0] mr;
      logic [22:0] frac;
      logic [7:0]  ef;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      sx = x[31];
      sy = y[31];
      ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
      ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
      mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
      my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
      d = ex - ey;
      sticky = 1'b0;
      for (int i = 0; i < 27; i++) begin
         if (10'(i) < d) sticky = sticky | my[i];
      end
      my = (d > 10'd26) ? 27'd0 : (my >> d);
      my[0] = my[0] | sticky;
      er = ex;
      if (sx == sy) begin
         s = {1'b0, mx} + {1'b0, my};
         if (s[27]) begin
            s = {1'b0, s[27:1]} | {27'd0, s[0]};
            er = er + 10'd1;
         end
      end else begin
         s = {1'b0, mx} - {1'b0, my};
         for (int i = 0; i < 26; i++) begin
            if (!s[26] && er > 10'd1) begin
               s = s << 1;
               er = er - 10'd1;
            end
         end
      end
      m = s[26:0];
      rnd = m[2] & (m[1] | m[0] | m[3]);
      mr = {1'b0, m[26:3]} + {24'd0, rnd};
      if (mr[24]) begin
         er = er + 10'd1;
         frac = mr[23:1];
      end else begin
         frac = mr[22:0];
      end
      is_norm = mr[24] | mr[23];
      ef = is_norm ? er[7:0] : 8'd0;
      sr = (m == 27'd0 && sx != sy) ? 1'b0 : sx;
      exc = (x[30:23] == 8'hFF) | (y[30:23] == 8'hFF)
          | (is_norm & (er >= 10'd255));
      return {exc, sr, ef, frac};
   endfunction

   // Ordered greater-than; potentials never hold NaN.
   function automatic logic fp_gt(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic r;
      case ({a[31], b[31]})
         2'b00:   r = a[30:0] > b[30:0];
         2'b01:   r = (a[30:0] | b[30:0]) != 31'd0;
         2'b10:   r = 1'b0;
         default: r = a[30:0] < b[30:0];
      endcase
      return r;
   endfunction

   assign id_ok = {{(32-ID_W){1'b0}}, in_neuron_id}
                < 32'(NUM_NEURONS);
   assign acc_cur  = id_ok ? pot_q[in_neuron_id] : 32'd0;
   assign eval_cur = pot_q[idx_q];
   assign acc_res  = fp_add(acc_cur, in_weight);
   assign sub_res  = fp_add(eval_cur, V_THRESHOLD ^ 32'h8000_0000);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pot_d    = pot_q;
      spike_d  = spike_q;
      err_id_d = err_id_q;
      err_fp_d = err_fp_q;
      if (clear) begin
         state_d = S_IDLE;
         idx_d   = '0;
         pot_d   = '0;
         spike_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  if (!id_ok) begin
                     err_id_d = 1'b1;
                  end else if (acc_res[32]) begin
                     err_fp_d = 1'b1;
                  end else begin
                     pot_d[in_neuron_id] = acc_res[31:0];
                  end
               end
               if (step) begin
                  state_d = S_EVAL;
                  idx_d   = '0;
                  spike_d = '0;
               end
            end
            S_EVAL: begin
               if (fp_gt(eval_cur, V_THRESHOLD)) begin
                  spike_d[idx_q] = 1'b1;
                  pot_d[idx_q]   = (RESET_MODE != 0) ? 32'd0
                                                     : sub_res[31:0];
               end
               if (idx_q == ID_W'(NUM_NEURONS - 1)) begin
                  state_d = S_DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         pot_q    <= '0;
         spike_q  <= '0;
         err_id_q <= 1'b0;
         err_fp_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         pot_q    <= pot_d;
         spike_q  <= spike_d;
         err_id_q <= err_id_d;
         err_fp_q <= err_fp_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign step_done = (state_q == S_DONE);
   assign spike_vec = spike_q;
   assign err_id    = err_id_q;
   assign err_fp    = err_fp_q;

`ifdef POTENTIAL_DEBUG_TAP_EN
   always_comb begin
      dbg_potential = 32'd0;
      if ({{(32-ID_W){1'b0}}, dbg_sel} < 32'(NUM_NEURONS)) begin
         dbg_potential = pot_q[dbg_sel];
      end
   end
   assign dbg_bits = dbg_potential[9:0];
`endif

endmodule

// File: tb/tb_potential_update_array.sv
// Directed bench for potential_update_array: accumulate, sweep, clear,
// reset abort, error flags, both reset modes and the optional debug tap.
module tb_potential_update_array;

   localparam logic [31:0] F20  = 32'h41A00000;
   localparam logic [31:0] F40  = 32'h42200000;
   localparam logic [31:0] F50  = 32'h42480000;
   localparam logic [31:0] F10  = 32'h41200000;
   localparam logic [31:0] FINF = 32'h7F800000;

   logic        CLK, RST, clear, step, in_valid;
   logic [1:0]  in_id;
   logic [31:0] in_weight;
   logic        in_valid2;
   logic [2:0]  in_id2;

   logic        rdy0, done0, busy0, eid0, efp0;
   logic [3:0]  spk0;
   logic        rdy1, done1, busy1, eid1, efp1;
   logic [3:0]  spk1;
   logic        rdy2, done2, busy2, eid2, efp2;
   logic [4:0]  spk2;

`ifdef POTENTIAL_DEBUG_TAP_EN
   logic [1:0]  dsel0, dsel1;
   logic [2:0]  dsel2;
   logic [31:0] dpot0, dpot1, dpot2;
   logic [9:0]  dbits0, dbits1, dbits2;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   potential_update_array #(.NUM_NEURONS(4), .RESET_MODE(0)) u0 (
      .CLK(CLK), .RST(RST), .clear(clear), .step(step),
      .in_valid(in_valid), .in_ready(rdy0),
      .in_neuron_id(in_id), .in_weight(in_weight),
`ifdef POTENTIAL_DEBUG_TAP_EN
      .dbg_sel(dsel0), .dbg_potential(dpot0), .dbg_bits(dbits0),
`endif
      .spike_vec(spk0), .step_done(done0), .busy(busy0),
      .err_id(eid0), .err_fp(efp0)
   );

   potential_update_array #(.NUM_NEURONS(4), .RESET_MODE(1)) u1 (
      .CLK(CLK), .RST(RST), .clear(clear), .step(step),
      .in_valid(in_valid), .in_ready(rdy1),
      .in_neuron_id(in_id), .in_weight(in_weight),
`ifdef POTENTIAL_DEBUG_TAP_EN
      .dbg_sel(dsel1), .dbg_potential(dpot1), .dbg_bits(dbits1),
`endif
      .spike_vec(spk1), .step_done(done1), .busy(busy1),
      .err_id(eid1), .err_fp(efp1)
   );

   potential_update_array #(.NUM_NEURONS(5), .RESET_MODE(0)) u2 (
      .CLK(CLK), .RST(RST), .clear(clear), .step(step),
      .in_valid(in_valid2), .in_ready(rdy2),
      .in_neuron_id(in_id2), .in_weight(in_weight),
`ifdef POTENTIAL_DEBUG_TAP_EN
      .dbg_sel(dsel2), .dbg_potential(dpot2), .dbg_bits(dbits2),
`endif
      .spike_vec(spk2), .step_done(done2), .busy(busy2),
      .err_id(eid2), .err_fp(efp2)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [1:0] id, input logic [31:0] w);
      in_valid  = 1'b1;
      in_id     = id;
      in_weight = w;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Leaves the bench in the DONE cycle; lat counts cycles from step.
   task automatic run_step(output int lat);
      step = 1'b1;
      tick();
      step = 1'b0;
      lat = 1;
      while (done0 !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      n_cmp++;
      if ({rdy0, busy0, done0, eid0, efp0} !== 5'b10000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 10000",
                  {rdy0, busy0, done0, eid0, efp0});
      end
      n_cmp++;
      if (spk0 !== 4'b0000 || u0.pot_q !== '0) begin
         n_bad++;
         $display("FAIL reset_state: spk %b pot %h want 0", spk0, u0.pot_q);
      end
   endtask

   task automatic test_accumulate_spike();
      int lat;
      send(2'd0, F20);
      send(2'd0, F20);
      send(2'd0, F20);
      n_cmp++;
      if (u0.pot_q[0] !== 32'h42700000) begin
         n_bad++;
         $display("FAIL acc_sum: got %h want 42700000", u0.pot_q[0]);
      end
      run_step(lat);
      n_cmp++;
      if (lat !== 5) begin
         n_bad++;
         $display("FAIL step_latency: got %0d want 5", lat);
      end
      n_cmp++;
      if (spk0 !== 4'b0001 || u0.pot_q[0] !== F20) begin
         n_bad++;
         $display("FAIL spike_sub: spk %b pot %h want 0001 %h",
                  spk0, u0.pot_q[0], F20);
      end
      tick();
      n_cmp++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || spk0 !== 4'b0001) begin
         n_bad++;
         $display("FAIL done_hold: done %b busy %b spk %b want 0 0 0001",
                  done0, busy0, spk0);
      end
`ifdef POTENTIAL_DEBUG_TAP_EN
      dsel0 = 2'd0;
      #1;
      n_cmp++;
      if (dpot0 !== F20 || dbits0 !== 10'h000) begin
         n_bad++;
         $display("FAIL dbg_tap: got %h %h want %h 000", dpot0, dbits0, F20);
      end
`endif
   endtask

   task automatic test_equal_threshold();
      int lat;
      send(2'd2, F20);
      send(2'd2, F20);
      run_step(lat);
      n_cmp++;
      if (spk0 !== 4'b0000 || u0.pot_q[2] !== F40 || u0.pot_q[0] !== F20) begin
         n_bad++;
         $display("FAIL eq_thresh: spk %b p2 %h p0 %h want 0000 %h %h",
                  spk0, u0.pot_q[2], u0.pot_q[0], F40, F20);
      end
      tick();
   endtask

   task automatic test_reset_mode();
      int lat;
      pulse_clear();
      send(2'd1, F50);
      run_step(lat);
      n_cmp++;
      if (spk0 !== 4'b0010 || u0.pot_q[1] !== F10) begin
         n_bad++;
         $display("FAIL mode0_sub: spk %b p1 %h want 0010 %h",
                  spk0, u0.pot_q[1], F10);
      end
      n_cmp++;
      if (spk1 !== 4'b0010 || u1.pot_q[1] !== 32'd0) begin
         n_bad++;
         $display("FAIL mode1_zero: spk %b p1 %h want 0010 0",
                  spk1, u1.pot_q[1]);
      end
      tick();
   endtask

   task automatic test_step_with_weight();
      int lat;
      logic blocked;
      pulse_clear();
      step      = 1'b1;
      in_valid  = 1'b1;
      in_id     = 2'd3;
      in_weight = F50;
      tick();
      in_id     = 2'd0;
      in_weight = F20;
      blocked   = (rdy0 === 1'b0) && (busy0 === 1'b1);
      lat = 1;
      while (done0 !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      step     = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if (!blocked || lat !== 5) begin
         n_bad++;
         $display("FAIL eval_block: blocked %b lat %0d want 1 5", blocked, lat);
      end
      n_cmp++;
      if (spk0 !== 4'b1000 || u0.pot_q[3] !== F10 || u0.pot_q[0] !== 32'd0) begin
         n_bad++;
         $display("FAIL step_weight: spk %b p3 %h p0 %h want 1000 %h 0",
                  spk0, u0.pot_q[3], u0.pot_q[0], F10);
      end
      tick();
      n_cmp++;
      if (busy0 !== 1'b0) begin
         n_bad++;
         $display("FAIL step_ignored: busy %b want 0", busy0);
      end
   endtask

   task automatic test_clear_abort();
      logic seen;
      send(2'd0, F50);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      clear = 1'b1;
      step  = 1'b1;
      tick();
      clear = 1'b0;
      step  = 1'b0;
      n_cmp++;
      if (busy0 !== 1'b0 || rdy0 !== 1'b1 || u0.pot_q !== '0 || spk0 !== 4'b0) begin
         n_bad++;
         $display("FAIL clear_abort: busy %b rdy %b pot %h spk %b want 0 1 0 0",
                  busy0, rdy0, u0.pot_q, spk0);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen = seen | done0;
         tick();
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_no_done: got %b want 0", seen);
      end
   endtask

   task automatic test_bad_id();
      pulse_clear();
      in_valid2 = 1'b1;
      in_id2    = 3'd2;
      in_weight = F20;
      tick();
      in_id2    = 3'd5;
      tick();
      in_valid2 = 1'b0;
      n_cmp++;
      if (eid2 !== 1'b1 || efp2 !== 1'b0) begin
         n_bad++;
         $display("FAIL err_id_set: eid %b efp %b want 1 0", eid2, efp2);
      end
      n_cmp++;
      if (u2.pot_q[2] !== F20 || u2.pot_q[4] !== 32'd0 ||
          u2.pot_q[1] !== 32'd0) begin
         n_bad++;
         $display("FAIL bad_id_pot: p2 %h p4 %h p1 %h want %h 0 0",
                  u2.pot_q[2], u2.pot_q[4], u2.pot_q[1], F20);
      end
      pulse_clear();
      n_cmp++;
      if (eid2 !== 1'b1) begin
         n_bad++;
         $display("FAIL err_id_sticky: got %b want 1", eid2);
      end
   endtask

   task automatic test_err_fp();
      send(2'd1, F20);
      send(2'd1, FINF);
      n_cmp++;
      if (efp0 !== 1'b1 || eid0 !== 1'b0 || u0.pot_q[1] !== F20) begin
         n_bad++;
         $display("FAIL err_fp: efp %b eid %b p1 %h want 1 0 %h",
                  efp0, eid0, u0.pot_q[1], F20);
      end
   endtask

   task automatic test_rst_mid_eval();
      logic seen;
      send(2'd0, F50);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_cmp++;
      if (busy0 !== 1'b0 || efp0 !== 1'b0 || eid2 !== 1'b0 || u0.pot_q !== '0) begin
         n_bad++;
         $display("FAIL rst_abort: busy %b efp %b eid %b pot %h want 0 0 0 0",
                  busy0, efp0, eid2, u0.pot_q);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen = seen | done0;
         tick();
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_no_done: got %b want 0", seen);
      end
   endtask

   initial begin
      RST       = 1'b1;
      clear     = 1'b0;
      step      = 1'b0;
      in_valid  = 1'b0;
      in_id     = 2'd0;
      in_weight = 32'd0;
      in_valid2 = 1'b0;
      in_id2    = 3'd0;
`ifdef POTENTIAL_DEBUG_TAP_EN
      dsel0 = 2'd0;
      dsel1 = 2'd0;
      dsel2 = 3'd0;
`endif
      test_reset();
      test_accumulate_spike();
      test_equal_threshold();
      test_reset_mode();
      test_step_with_weight();
      test_clear_abort();
      test_bad_id();
      test_err_fp();
      test_rst_mid_eval();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
